// File: rtl/braille_pkg.sv
// Shared definitions for the braille calculator input side.
//  - state_e      : sender FSM states
//  - CELL_0..14   : 6-bit braille cells (raster order, 1 = raised dot) per code
//  - SLOT_A/B/OP  : capture slot indices
package braille_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESSED = 3'd1,
    ST_SETUP   = 3'd2,
    ST_SEND_HI = 3'd3,
    ST_SEND_LO = 3'd4,
    ST_SETTLE  = 3'd5
  } state_e;

  localparam logic [5:0] CELL_0  = 6'b000111;
  localparam logic [5:0] CELL_1  = 6'b001000;
  localparam logic [5:0] CELL_2  = 6'b001010;
  localparam logic [5:0] CELL_3  = 6'b001100;
  localparam logic [5:0] CELL_4  = 6'b001101;
  localparam logic [5:0] CELL_5  = 6'b001001;
  localparam logic [5:0] CELL_6  = 6'b001110;
  localparam logic [5:0] CELL_7  = 6'b001111;
  localparam logic [5:0] CELL_8  = 6'b001011;
  localparam logic [5:0] CELL_9  = 6'b000101;
  localparam logic [5:0] CELL_10 = 6'b010011;
  localparam logic [5:0] CELL_11 = 6'b000011;
  localparam logic [5:0] CELL_12 = 6'b100001;
  localparam logic [5:0] CELL_13 = 6'b010010;
  localparam logic [5:0] CELL_14 = 6'b111111;

  localparam logic [1:0] SLOT_A  = 2'd0;
  localparam logic [1:0] SLOT_B  = 2'd1;
  localparam logic [1:0] SLOT_OP = 2'd2;

endpackage

// File: rtl/braille_cell_lookup.sv
// Combinational braille cell -> 4-bit code decoder (inverse of the output cell table).
// Ports:
//  cell_i   in  6  braille cell, raster order
//  valid_o  out 1  cell is one of the 15 known cells
//  code_o   out 4  decoded code (0 when invalid; 15 never produced)
module braille_cell_lookup
  import braille_pkg::*;
(
  input  logic [5:0] cell_i,
  output logic       valid_o,
  output logic [3:0] code_o
);

  // Table decode; anything not in the table is rejected.
  always_comb begin
    valid_o = 1'b1;
    code_o  = 4'd0;
    case (cell_i)
      CELL_0:  code_o = 4'd0;
      CELL_1:  code_o = 4'd1;
      CELL_2:  code_o = 4'd2;
      CELL_3:  code_o = 4'd3;
      CELL_4:  code_o = 4'd4;
      CELL_5:  code_o = 4'd5;
      CELL_6:  code_o = 4'd6;
      CELL_7:  code_o = 4'd7;
      CELL_8:  code_o = 4'd8;
      CELL_9:  code_o = 4'd9;
      CELL_10: code_o = 4'd10;
      CELL_11: code_o = 4'd11;
      CELL_12: code_o = 4'd12;
      CELL_13: code_o = 4'd13;
      CELL_14: code_o = 4'd14;
      default: begin
        valid_o = 1'b0;
        code_o  = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/braille_cell_sender.sv
// Captures operand A, operand B and operator as braille cells keyed on switches,
// then replays the three codes into the calculator's go/data_in handshake.
// Ports:
//  clk, resetn  clock and synchronous active-low reset
//  cell_in   in  6  braille cell from switches
//  key_go    in  1  entry key, active-high level
//  calc_go   out 1  calculator go
//  calc_data out 4  calculator data_in
//  slot_idx  out 2  next slot to capture (0=A, 1=B, 2=OP)
//  busy      out 1  replay in progress
//  err       out 1  sticky: last captured cell was rejected
//  done      out 1  one-cycle pulse at end of settle time
module braille_cell_sender
  import braille_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] cell_in,
  input  logic       key_go,
  output logic       calc_go,
  output logic [3:0] calc_data,
  output logic [1:0] slot_idx,
  output logic       busy,
  output logic       err,
  output logic       done
);

  localparam int unsigned MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_P  = (MAX_HG > SETTLE_CYCLES) ? MAX_HG : SETTLE_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       word_q;
  logic [3:0]       slot_a_q;
  logic [3:0]       slot_b_q;
  logic [3:0]       slot_op_q;

  logic             lut_valid;
  logic [3:0]       lut_code;
  logic             accept;
  logic [1:0]       next_word;
  logic [3:0]       next_word_data;

  braille_cell_lookup u_lookup (
    .cell_i  (cell_in),
    .valid_o (lut_valid),
    .code_o  (lut_code)
  );

  // Accept decision and data of the word that follows the current one.
  always_comb begin
    accept         = 1'b0;
    next_word      = word_q + 2'd1;
    next_word_data = 4'd0;
    // The operator slot only takes codes 0..3 so bits [3:2] of the OP word stay 0.
    if (slot_idx == SLOT_OP) begin
      accept = lut_valid && (lut_code[3:2] == 2'b00);
    end else begin
      accept = lut_valid;
    end
    case (next_word)
      SLOT_A:  next_word_data = slot_a_q;
      SLOT_B:  next_word_data = slot_b_q;
      SLOT_OP: next_word_data = slot_op_q;
      default: next_word_data = 4'd0;
    endcase
  end

  // Sender FSM with counter, slot registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      word_q    <= 2'd0;
      slot_a_q  <= 4'd0;
      slot_b_q  <= 4'd0;
      slot_op_q <= 4'd0;
      calc_go   <= 1'b0;
      calc_data <= 4'd0;
      slot_idx  <= SLOT_A;
      busy      <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_go) begin
            state_q <= ST_PRESSED;
          end
        end
        // Cell is sampled only on the release cycle.
        ST_PRESSED: begin
          if (!key_go) begin
            if (!accept) begin
              err     <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              err <= 1'b0;
              case (slot_idx)
                SLOT_A: begin
                  slot_a_q <= lut_code;
                  slot_idx <= SLOT_B;
                  state_q  <= ST_IDLE;
                end
                SLOT_B: begin
                  slot_b_q <= lut_code;
                  slot_idx <= SLOT_OP;
                  state_q  <= ST_IDLE;
                end
                default: begin
                  // Data for word 0 is presented during SETUP, one cycle ahead of go.
                  slot_op_q <= lut_code;
                  word_q    <= 2'd0;
                  calc_data <= slot_a_q;
                  busy      <= 1'b1;
                  state_q   <= ST_SETUP;
                end
              endcase
            end
          end
        end
        ST_SETUP: begin
          calc_go <= 1'b1;
          cnt_q   <= HOLD_LOAD;
          state_q <= ST_SEND_HI;
        end
        ST_SEND_HI: begin
          if (cnt_q == CNT_ZERO) begin
            calc_go <= 1'b0;
            cnt_q   <= GAP_LOAD;
            state_q <= ST_SEND_LO;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_SEND_LO: begin
          if (cnt_q == CNT_ZERO) begin
            if (word_q < SLOT_OP) begin
              word_q    <= next_word;
              calc_data <= next_word_data;
              state_q   <= ST_SETUP;
            end else begin
              cnt_q   <= SETTLE_LOAD;
              state_q <= ST_SETTLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_ZERO) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            slot_idx <= SLOT_A;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          calc_go <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_braille_cell_sender.sv
// Directed self-checking bench for braille_cell_sender.
module tb_braille_cell_sender;

  logic       clk;
  logic       resetn;
  logic [5:0] cell_in;
  logic       key_go;
  logic       calc_go;
  logic [3:0] calc_data;
  logic [1:0] slot_idx;
  logic       busy;
  logic       err;
  logic       done;

  logic [5:0] ref_cell;
  logic       ref_valid;
  logic [3:0] ref_code;

  int n_checks = 0;
  int n_pass   = 0;

  braille_cell_sender #(
    .HOLD_CYCLES  (4),
    .GAP_CYCLES   (4),
    .SETTLE_CYCLES(64)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cell_in  (cell_in),
    .key_go   (key_go),
    .calc_go  (calc_go),
    .calc_data(calc_data),
    .slot_idx (slot_idx),
    .busy     (busy),
    .err      (err),
    .done     (done)
  );

  braille_cell_lookup u_ref (
    .cell_i (ref_cell),
    .valid_o(ref_valid),
    .code_o (ref_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Two cycles high, then released; returns at the negedge after capture.
  task automatic press(input logic [5:0] c);
    cell_in = c;
    key_go  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    key_go = 1'b0;
    @(negedge clk);
  endtask

  // Called at the negedge right after the operator capture (first SETUP cycle).
  // Word k: 1 SETUP + 4 go-high + 4 go-low = 9 cycles; then 64 settle; then done.
  task automatic run_send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                          input bit pulse_key);
    int done_cnt;
    int go_hi_cnt;
    logic [3:0] wv;
    done_cnt  = 0;
    go_hi_cnt = 0;
    for (int k = 0; k < 93; k++) begin
      if (pulse_key) begin
        key_go = (k == 2 || k == 6 || k == 12 || k == 30 || k == 50) ? 1'b1 : 1'b0;
      end
      if (done) done_cnt++;
      if (calc_go) go_hi_cnt++;
      if (k < 27) begin
        wv = (k < 9) ? a : ((k < 18) ? b : op);
        check($sformatf("data k=%0d", k), calc_data, wv);
        check($sformatf("go k=%0d", k), calc_go, ((k % 9) >= 1 && (k % 9) <= 4) ? 1 : 0);
        check($sformatf("busy k=%0d", k), busy, 1);
      end else if (k < 91) begin
        check($sformatf("settle go k=%0d", k), calc_go, 0);
        check($sformatf("settle busy k=%0d", k), busy, 1);
        check($sformatf("settle done k=%0d", k), done, 0);
      end else if (k == 91) begin
        check("done pulse", done, 1);
        check("done busy", busy, 0);
        check("done slot_idx", slot_idx, 0);
      end else begin
        check("done one cycle", done, 0);
        check("idle holds data", calc_data, op);
      end
      @(negedge clk);
    end
    key_go = 1'b0;
    check("done count", done_cnt, 1);
    check("go high cycles", go_hi_cnt, 12);
  endtask

  logic [5:0] cell_tab [0:14];
  int         exp_code;

  initial begin
    cell_tab[0]  = 6'b000111; cell_tab[1]  = 6'b001000; cell_tab[2]  = 6'b001010;
    cell_tab[3]  = 6'b001100; cell_tab[4]  = 6'b001101; cell_tab[5]  = 6'b001001;
    cell_tab[6]  = 6'b001110; cell_tab[7]  = 6'b001111; cell_tab[8]  = 6'b001011;
    cell_tab[9]  = 6'b000101; cell_tab[10] = 6'b010011; cell_tab[11] = 6'b000011;
    cell_tab[12] = 6'b100001; cell_tab[13] = 6'b010010; cell_tab[14] = 6'b111111;

    resetn   = 1'b0;
    key_go   = 1'b0;
    cell_in  = 6'd0;
    ref_cell = 6'd0;

    // Exhaustive cell map against the hand table.
    for (int c = 0; c < 64; c++) begin
      ref_cell = 6'(c);
      exp_code = -1;
      for (int i = 0; i < 15; i++) begin
        if (cell_tab[i] == 6'(c)) exp_code = i;
      end
      #1;
      check($sformatf("lut valid %0d", c), ref_valid, (exp_code >= 0) ? 1 : 0);
      if (exp_code >= 0) begin
        check($sformatf("lut code %0d", c), ref_code, exp_code);
      end
    end

    // 1. Reset held 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst calc_go", calc_go, 0);
    check("rst calc_data", calc_data, 0);
    check("rst slot_idx", slot_idx, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    check("rst done", done, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("post-rst calc_go", calc_go, 0);
    check("post-rst busy", busy, 0);

    // 2. 3 + 2 (add).
    press(6'b001100);
    check("t2 slot_idx A->B", slot_idx, 1);
    press(6'b001010);
    check("t2 slot_idx B->OP", slot_idx, 2);
    press(6'b000111);
    check("t2 err", err, 0);
    run_send(4'd3, 4'd2, 4'd0, 1'b0);

    // 3. Invalid cell at slot 0, then valid.
    press(6'b101010);
    check("t3 err set", err, 1);
    check("t3 slot_idx", slot_idx, 0);
    check("t3 busy", busy, 0);
    repeat (3) @(negedge clk);
    check("t3 no go", calc_go, 0);
    press(6'b001000);
    check("t3 err clr", err, 0);
    check("t3 slot_idx", slot_idx, 1);

    // 4. Operator slot rejects codes > 3.
    press(6'b001100);
    check("t4 slot_idx", slot_idx, 2);
    press(6'b001101);
    check("t4 op4 err", err, 1);
    check("t4 op4 slot_idx", slot_idx, 2);
    check("t4 op4 busy", busy, 0);
    press(6'b001111);
    check("t4 op7 err", err, 1);
    check("t4 op7 busy", busy, 0);
    press(6'b001000);
    check("t4 op1 err", err, 0);
    check("t4 op1 busy", busy, 1);
    run_send(4'd1, 4'd3, 4'd1, 1'b0);

    // 5. Key activity while busy is ignored.
    press(6'b001101);
    press(6'b000101);
    press(6'b001010);
    run_send(4'd4, 4'd9, 4'd2, 1'b1);
    check("t5 slot_idx", slot_idx, 0);
    check("t5 err", err, 0);

    // 6. Reset during the second SEND_HI.
    press(6'b001000);
    press(6'b001010);
    press(6'b001100);
    for (int k = 0; k < 11; k++) @(negedge clk);
    check("t6 go before rst", calc_go, 1);
    check("t6 data before rst", calc_data, 2);
    resetn = 1'b0;
    @(negedge clk);
    check("t6 rst calc_go", calc_go, 0);
    check("t6 rst busy", busy, 0);
    check("t6 rst slot_idx", slot_idx, 0);
    check("t6 rst calc_data", calc_data, 0);
    resetn = 1'b1;
    @(negedge clk);
    press(6'b001000);
    check("t6 new entry slot_idx", slot_idx, 1);
    press(6'b000111);
    press(6'b001000);
    run_send(4'd1, 4'd0, 4'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
